// File: rtl/signed_mult_display_pkg.sv
// Shared types and constants for the signed multiply-and-display block.
// Holds the FSM state encoding, the segment code table and the BCD digit count helper.
package signed_mult_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    CONV,
    SHOW
  } state_t;

  // Segment patterns are active-low: bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  localparam logic [6:0] SEG_CODE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // Decimal digits needed for a (2w-1)-bit magnitude; 30103/100000 approximates log10(2)
  function automatic int nbcd(input int w);
    return ((2 * w - 1) * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/signed_mult_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Blank request or any non-decimal code produces an all-off pattern.
module seg7_decode
  import signed_mult_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_CODE[digit];
    end
  end

endmodule

// File: rtl/signed_mult_display.sv
// Iterative signed multiply, serial double-dabble BCD conversion and a scrolled, scanned 7-segment readout.
// A start sampled in IDLE/SHOW yields done exactly 3W edges later; scroll and scan run independently.
module signed_mult_display
  import signed_mult_display_pkg::*;
#(
  parameter int W           = 8,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      X,
  input  logic [W-1:0]      Y,
  input  logic              start,
  input  logic              scroll_left,
  input  logic              scroll_right,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    product,
  output logic [6:0]        segments,
  output logic [NDIG-1:0]   anode
);

  localparam int NBCD    = nbcd(W);
  localparam int OFF_MAX = NBCD - (NDIG - 1);
  localparam int CW      = $clog2(2 * W);
  localparam int OW      = $clog2(NBCD + 1);
  localparam int SW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t              state;
  logic [2*W-1:0]      mx;
  logic [W-1:0]        mq;
  logic [2*W-1:0]      acc;
  logic                sgn;
  logic                neg;
  logic [CW-1:0]       cnt;
  logic [2*W-2:0]      bin;
  logic [4*NBCD-1:0]   bcd;
  logic [4*NBCD-1:0]   bcd_adj;
  logic [OW-1:0]       offset;
  logic                sl_q;
  logic                sr_q;
  logic                left_edge;
  logic                right_edge;
  logic [DW-1:0]       div_cnt;
  logic [SW-1:0]       scan_idx;

  logic [W-1:0]        ax;
  logic [W-1:0]        ay;

  // Unsigned magnitudes; -2^(W-1) maps to 2^(W-1), which still fits in W bits
  assign ax = X[W-1] ? -X : X;
  assign ay = Y[W-1] ? -Y : Y;

  assign left_edge  = scroll_left & ~sl_q;
  assign right_edge = scroll_right & ~sr_q;

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NBCD; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mx      <= '0;
      mq      <= '0;
      acc     <= '0;
      sgn     <= 1'b0;
      neg     <= 1'b0;
      cnt     <= '0;
      bin     <= '0;
      bcd     <= '0;
      offset  <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      sl_q <= scroll_left;
      sr_q <= scroll_right;
      done <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (start) begin
            mx     <= {{W{1'b0}}, ax};
            mq     <= ay;
            acc    <= '0;
            sgn    <= X[W-1] ^ Y[W-1];
            cnt    <= '0;
            offset <= '0;
            busy   <= 1'b1;
            state  <= MULT;
          end else if (state == SHOW) begin
            if (left_edge && !right_edge && (offset < OW'(OFF_MAX))) begin
              offset <= offset + OW'(1);
            end else if (right_edge && !left_edge && (offset != '0)) begin
              offset <= offset - OW'(1);
            end
          end
        end
        MULT: begin
          if (mq[0]) begin
            acc <= acc + mx;
          end
          mx  <= mx << 1;
          mq  <= mq >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          // First CONV cycle loads the magnitude; the next 2W-1 cycles shift it in
          if (cnt == '0) begin
            bin <= acc[2*W-2:0];
            bcd <= '0;
          end else begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(2 * W - 1)) begin
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            neg     <= sgn && (acc != '0);
            product <= (sgn && (acc != '0)) ? -acc : acc;
            state   <= SHOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DW'(REFRESH_DIV - 1)) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == SW'(NDIG - 1)) ? '0 : scan_idx + SW'(1);
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  logic [NBCD-1:0] zero_from;
  logic            all_zero;
  int              d;
  logic [3:0]      cur_dig;
  logic            cur_blank;
  logic [6:0]      dec_seg;

  // zero_from[k] is set when digit k and every more-significant digit are zero
  always_comb begin
    all_zero  = 1'b1;
    zero_from = '0;
    for (int k = NBCD - 1; k >= 0; k--) begin
      all_zero     = all_zero && (bcd[4*k +: 4] == 4'd0);
      zero_from[k] = all_zero;
    end
  end

  always_comb begin
    d         = NBCD - 1 - int'(offset) - (NDIG - 2 - int'(scan_idx));
    cur_dig   = 4'd0;
    cur_blank = 1'b1;
    if ((d >= 0) && (d < NBCD)) begin
      cur_dig   = bcd[4*d +: 4];
      cur_blank = (state != SHOW) || ((BLANK_LZ != 0) && (d > 0) && zero_from[d]);
    end
  end

  seg7_decode u_seg7_decode (
    .digit (cur_dig),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    anode = ~(NDIG'(1) << scan_idx);
    if (scan_idx == SW'(NDIG - 1)) begin
      segments = ((state == SHOW) && neg) ? SEG_MINUS : SEG_BLANK;
    end else begin
      segments = dec_seg;
    end
  end

endmodule

// File: tb/tb_signed_mult_display.sv
// Bench for signed_mult_display at W=8, NDIG=4, REFRESH_DIV=4: vector table plus scroll/abort sequences.
module tb_signed_mult_display;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b1111110;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S8 = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic        start = 1'b0;
  logic        scroll_left = 1'b0;
  logic        scroll_right = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [6:0]  segments;
  logic [3:0]  anode;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] prod;
    logic [6:0]  sgn;
    int          nl;
    logic [6:0]  d2;
    logic [6:0]  d1;
    logic [6:0]  d0;
  } vec_t;

  vec_t vecs[7];

  signed_mult_display #(
    .W(8), .NDIG(4), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .X            (X),
    .Y            (Y),
    .start        (start),
    .scroll_left  (scroll_left),
    .scroll_right (scroll_right),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .segments     (segments),
    .anode        (anode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_digit(input int i, output logic [6:0] seg, output logic found);
    logic [3:0] want;
    want  = ~(4'b0001 << i);
    found = 1'b0;
    seg   = '0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (anode === want) begin
        seg   = segments;
        found = 1'b1;
      end
    end
  endtask

  task automatic show_check(input string tag, input logic [6:0] es, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp [4];
    logic [6:0] seg;
    logic       found;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = es;
    for (int i = 0; i < 4; i++) begin
      read_digit(i, seg, found);
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL %s_anode%0d: scan never selected this digit", tag, i);
      end else begin
        chk($sformatf("%s_seg%0d", tag, i), {25'd0, seg}, {25'd0, exp[i]});
      end
    end
  endtask

  // Drives one operation, checks busy/done timing and the product via the scoreboard.
  // A nonzero pulse_at raises start (with other operands) for the edge of that number.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                        input int pulse_at);
    logic ok;
    X = x; Y = y; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == pulse_at) begin
        X = 8'd1; Y = 8'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      if (k == pulse_at) start = 1'b0;
      if (k < 24 && (busy !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    chk("busy_window", {31'd0, ok}, 32'd1);
    chk("done_at_24", {30'd0, done, busy}, 32'd2);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL product: done with empty scoreboard, got %h", product);
      end else begin
        chk("product", {16'd0, product}, {16'd0, sb.pop_front()});
      end
    end
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic scroll_l();
    scroll_left = 1'b1; @(posedge clk); #1;
    scroll_left = 1'b0; @(posedge clk); #1;
  endtask

  task automatic scroll_r();
    scroll_right = 1'b1; @(posedge clk); #1;
    scroll_right = 1'b0; @(posedge clk); #1;
  endtask

  initial begin
    logic ok;
    vecs[0] = '{8'd12,  8'd10,  16'd120,   SB, 0, SB, SB, S1};
    vecs[1] = '{8'd12,  8'd10,  16'd120,   SB, 2, S1, S2, S0};
    vecs[2] = '{8'h80,  8'h80,  16'h4000,  SB, 0, S1, S6, S3};
    vecs[3] = '{8'hFD,  8'd5,   16'hFFF1,  SM, 2, SB, S1, S5};
    vecs[4] = '{8'd0,   8'hF9,  16'h0000,  SB, 2, SB, SB, S0};
    vecs[5] = '{8'h7F,  8'h80,  16'hC080,  SM, 0, S1, S6, S2};
    vecs[6] = '{8'hFF,  8'hFF,  16'h0001,  SB, 2, SB, SB, S1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_anode", {28'd0, anode}, 32'hE);
    chk("rst_segments", {25'd0, segments}, {25'd0, SB});
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].x, vecs[v].y, vecs[v].prod, 0);
      for (int n = 0; n < vecs[v].nl; n++) scroll_l();
      show_check($sformatf("vec%0d", v), vecs[v].sgn, vecs[v].d2, vecs[v].d1, vecs[v].d0);
    end

    // Scroll saturation, held level and simultaneous edges on 16384 (digits 1,6,3,8,4)
    run_op(8'h80, 8'h80, 16'h4000, 0);
    scroll_r();
    show_check("sat_right", SB, S1, S6, S3);
    repeat (3) scroll_l();
    show_check("sat_left", SB, S3, S8, S4);
    repeat (2) scroll_r();
    show_check("back_to_0", SB, S1, S6, S3);
    scroll_left = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    scroll_left = 1'b0;
    @(posedge clk); #1;
    show_check("held_left", SB, S6, S3, S8);
    scroll_left = 1'b1; scroll_right = 1'b1;
    @(posedge clk); #1;
    scroll_left = 1'b0; scroll_right = 1'b0;
    @(posedge clk); #1;
    show_check("both_edges", SB, S6, S3, S8);

    // start pulsed during CONV must not disturb the running operation
    run_op(8'd12, 8'd10, 16'd120, 12);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) ok = 1'b0;
    end
    chk("ignored_start_idle", {31'd0, ok}, 32'd1);
    chk("ignored_start_product", {16'd0, product}, 32'd120);

    // Reset in the middle of MULT aborts without a done pulse
    X = 8'd3; Y = 8'd7; start = 1'b1;
    sb.push_back(16'd21);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_mult_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_segments", {25'd0, segments}, {25'd0, SB});
    chk("abort_anode", {28'd0, anode}, 32'hE);
    rst = 1'b0;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_done", {31'd0, ok}, 32'd1);
    chk("abort_product", {16'd0, product}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
